// File: rtl/ahb2apb_bridge_if.sv
// Bus bundle for the AHB-lite to APB4 bridge: AHB slave-side signals plus
// the APB peripheral bus. "slave" is the bridge view, "master" is the
// system view (AHB master/mux plus APB peripherals).
interface ahb2apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PSEL   = 4
);
    // AHB side
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [1:0]            HSIZE;
    logic [1:0]            HTRANS;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    // APB side
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [NUM_PSEL-1:0]   PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave that turns each single AHB transfer into one APB4 transfer.
// Page HADDR[15:12] selects one of NUM_PSEL peripherals. Decode errors,
// PSLVERR and a PREADY timeout all produce the two-cycle AHB ERROR response.
module ahb2apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_PSEL   = 4,
    parameter int TIMEOUT    = 16
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb2apb_bridge_if.slave  bus
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    // Decoded view of the current AHB address phase
    typedef struct packed {
        logic                err;
        logic [NUM_PSEL-1:0] sel;
        logic [3:0]          strb;
    } dec_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [31:0]           hrdata_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [NUM_PSEL-1:0]   psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [3:0]            pstrb_q;

    logic                  accept;
    logic [3:0]            page;
    dec_t                  dec;

    // HTRANS[0] only distinguishes SEQ/NONSEQ, which this bridge treats alike
    logic unused_htrans0;
    assign unused_htrans0 = bus.HTRANS[0];

    // A transfer is taken only for NONSEQ/SEQ while the bus is ready
    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

    // Address decode: page range, size legality, alignment and byte strobes
    always_comb begin
        page     = bus.HADDR[15:12];
        dec.err  = 1'b0;
        dec.strb = 4'b0000;
        if (int'(page) >= NUM_PSEL)
            dec.err = 1'b1;
        case (bus.HSIZE)
            2'd0: dec.strb = 4'b0001 << bus.HADDR[1:0];
            2'd1: begin
                dec.strb = bus.HADDR[1] ? 4'b1100 : 4'b0011;
                if (bus.HADDR[0])
                    dec.err = 1'b1;
            end
            2'd2: begin
                dec.strb = 4'b1111;
                if (bus.HADDR[1:0] != 2'b00)
                    dec.err = 1'b1;
            end
            default: dec.err = 1'b1;
        endcase
        if (!bus.HWRITE)
            dec.strb = 4'b0000;
        dec.sel = dec.err ? '0 : (NUM_PSEL'(1) << page);
    end

    // Bridge FSM with all bus outputs registered alongside the state
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            paddr_q     <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    state       <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    psel_q      <= '0;
                    penable_q   <= 1'b0;
                    if (accept) begin
                        hreadyout_q <= 1'b0;
                        if (dec.err) begin
                            // No APB activity for a transfer that cannot decode
                            state   <= S_ERR1;
                            hresp_q <= 1'b1;
                        end else begin
                            state    <= S_SETUP;
                            cnt      <= '0;
                            paddr_q  <= bus.HADDR;
                            pwrite_q <= bus.HWRITE;
                            pstrb_q  <= dec.strb;
                            psel_q   <= dec.sel;
                        end
                    end
                end
                S_SETUP: begin
                    state     <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (bus.PSLVERR) begin
                            state   <= S_ERR1;
                            hresp_q <= 1'b1;
                        end else begin
                            state       <= S_DONE;
                            hreadyout_q <= 1'b1;
                            if (!pwrite_q)
                                hrdata_q <= bus.PRDATA;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Hung peripheral: abandon the APB access and error out
                        state     <= S_ERR1;
                        hresp_q   <= 1'b1;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ERR1: begin
                    state       <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                S_ERR2: begin
                    // Master cancels after ERROR, so anything sampled here is dropped
                    state       <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    psel_q      <= '0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    // Write data flows straight through while a write is on the APB bus;
    // AHB holds HWDATA stable because HREADYOUT is low in those states
    assign bus.PWDATA = (pwrite_q && (state == S_SETUP || state == S_ACCESS))
                        ? bus.HWDATA : 32'h0;

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSTRB     = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: inputs change 1 ns after each rising
// edge, outputs are checked 2 ns after it.
module tb_ahb2apb_bridge;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks   = 0;
    int   failures = 0;
    int   waits;
    int   acc;

    ahb2apb_bridge_if #(.ADDR_WIDTH(32), .NUM_PSEL(4)) bus ();

    ahb2apb_bridge #(.ADDR_WIDTH(32), .NUM_PSEL(4), .TIMEOUT(16)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic ahb_addr(input logic [31:0] a, input logic wr, input logic [1:0] sz);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = a;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
    endtask

    task automatic ahb_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
    endtask

    initial begin
        HRESET     = 1'b1;
        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 2'd0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = '0;
        bus.HREADY = 1'b1;
        bus.PRDATA = '0;
        bus.PREADY = 1'b1;
        bus.PSLVERR = 1'b0;
        step();
        step();
        HRESET = 1'b0;
        #1;
        // ---- reset values
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rst_hresp",     32'(bus.HRESP),     32'h0);
        chk("rst_hrdata",    bus.HRDATA,         32'h0);
        chk("rst_psel",      32'(bus.PSEL),      32'h0);
        chk("rst_penable",   32'(bus.PENABLE),   32'h0);
        chk("rst_paddr",     bus.PADDR,          32'h0);
        chk("rst_pstrb",     32'(bus.PSTRB),     32'h0);
        chk("rst_pwdata",    bus.PWDATA,         32'h0);

        // ---- BUSY and HREADY-low transfers are not accepted
        step(); ahb_addr(32'h2004, 1'b1, 2'd2); bus.HTRANS = 2'b01; #1;
        step(); bus.HTRANS = 2'b10; bus.HREADY = 1'b0; #1;
        chk("busy_ignored_psel",      32'(bus.PSEL),      32'h0);
        chk("busy_ignored_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        step(); bus.HREADY = 1'b1; ahb_idle(); #1;
        chk("hready_lo_ignored_psel", 32'(bus.PSEL),      32'h0);

        // ---- word write 0x2004, zero-wait
        step(); ahb_addr(32'h2004, 1'b1, 2'd2); #1;
        chk("wr_addr_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        step(); ahb_idle(); bus.HWDATA = 32'hDEADBEEF; bus.PREADY = 1'b1; #1;
        chk("wr_setup_psel",      32'(bus.PSEL),      32'h4);
        chk("wr_setup_penable",   32'(bus.PENABLE),   32'h0);
        chk("wr_setup_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        chk("wr_setup_pstrb",     32'(bus.PSTRB),     32'hF);
        chk("wr_setup_paddr",     bus.PADDR,          32'h2004);
        chk("wr_setup_pwrite",    32'(bus.PWRITE),    32'h1);
        chk("wr_setup_pwdata",    bus.PWDATA,         32'hDEADBEEF);
        step(); #1;
        chk("wr_access_penable",   32'(bus.PENABLE),   32'h1);
        chk("wr_access_psel",      32'(bus.PSEL),      32'h4);
        chk("wr_access_pwdata",    bus.PWDATA,         32'hDEADBEEF);
        chk("wr_access_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        step(); #1;
        chk("wr_done_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("wr_done_hresp",     32'(bus.HRESP),     32'h0);
        chk("wr_done_psel",      32'(bus.PSEL),      32'h0);
        chk("wr_done_pwdata",    bus.PWDATA,         32'h0);

        // ---- word read 0x1008 with PREADY low for 3 ACCESS cycles
        step(); ahb_addr(32'h1008, 1'b0, 2'd2); #1;
        waits = 0;
        step(); ahb_idle(); bus.PREADY = 1'b0; #1;
        chk("rd_setup_psel",   32'(bus.PSEL),  32'h2);
        chk("rd_setup_pstrb",  32'(bus.PSTRB), 32'h0);
        chk("rd_setup_paddr",  bus.PADDR,      32'h1008);
        chk("rd_setup_pwdata", bus.PWDATA,     32'h0);
        if (!bus.HREADYOUT) waits++;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("rd_wait_penable", 32'(bus.PENABLE), 32'h1);
            if (!bus.HREADYOUT) waits++;
        end
        step(); bus.PREADY = 1'b1; bus.PRDATA = 32'h12345678; #1;
        if (!bus.HREADYOUT) waits++;
        chk("rd_hrdata_hold", bus.HRDATA, 32'h0);
        step(); bus.PRDATA = 32'h0BADF00D; #1;
        chk("rd_wait_states",     waits,              32'd5);
        chk("rd_done_hreadyout",  32'(bus.HREADYOUT), 32'h1);
        chk("rd_done_hrdata",     bus.HRDATA,         32'h12345678);

        // ---- byte write 0x3 then back-to-back half write 0x2
        step(); ahb_addr(32'h0003, 1'b1, 2'd0); #1;
        step(); ahb_idle(); bus.HWDATA = 32'hAA000000; #1;
        chk("b_setup_pstrb", 32'(bus.PSTRB), 32'h8);
        chk("b_setup_psel",  32'(bus.PSEL),  32'h1);
        step(); #1;
        step(); ahb_addr(32'h0002, 1'b1, 2'd1); #1;
        chk("b_done_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("b_done_hresp",     32'(bus.HRESP),     32'h0);
        step(); ahb_idle(); bus.HWDATA = 32'hBBBB0000; #1;
        chk("h_setup_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        chk("h_setup_psel",      32'(bus.PSEL),      32'h1);
        chk("h_setup_penable",   32'(bus.PENABLE),   32'h0);
        chk("h_setup_pstrb",     32'(bus.PSTRB),     32'hC);
        chk("h_setup_paddr",     bus.PADDR,          32'h0002);
        chk("h_setup_pwdata",    bus.PWDATA,         32'hBBBB0000);
        step(); #1;
        chk("h_access_penable", 32'(bus.PENABLE), 32'h1);
        step(); #1;
        chk("h_done_hreadyout", 32'(bus.HREADYOUT), 32'h1);

        // ---- page 5 decode error, then misaligned word, then ignored ERR2 transfer
        step(); ahb_addr(32'h5000, 1'b0, 2'd2); #1;
        step(); ahb_idle(); #1;
        chk("pg_err1_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        chk("pg_err1_hresp",     32'(bus.HRESP),     32'h1);
        chk("pg_err1_psel",      32'(bus.PSEL),      32'h0);
        step(); #1;
        chk("pg_err2_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("pg_err2_hresp",     32'(bus.HRESP),     32'h1);
        chk("pg_err2_psel",      32'(bus.PSEL),      32'h0);
        step(); ahb_addr(32'h0002, 1'b1, 2'd2); #1;
        chk("pg_idle_hresp", 32'(bus.HRESP), 32'h0);
        step(); ahb_idle(); #1;
        chk("mis_err1_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        chk("mis_err1_hresp",     32'(bus.HRESP),     32'h1);
        chk("mis_err1_psel",      32'(bus.PSEL),      32'h0);
        step(); ahb_addr(32'h0000, 1'b1, 2'd2); #1;
        chk("mis_err2_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("mis_err2_hresp",     32'(bus.HRESP),     32'h1);
        step(); ahb_idle(); #1;
        chk("err2_ignored_psel",      32'(bus.PSEL),      32'h0);
        chk("err2_ignored_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("err2_ignored_hresp",     32'(bus.HRESP),     32'h0);

        // ---- PSLVERR with PREADY
        step(); ahb_addr(32'h3000, 1'b1, 2'd2); #1;
        step(); ahb_idle(); bus.HWDATA = 32'h55AA55AA; #1;
        chk("se_setup_psel", 32'(bus.PSEL), 32'h8);
        step(); bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; #1;
        step(); bus.PSLVERR = 1'b0; #1;
        chk("se_err1_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        chk("se_err1_hresp",     32'(bus.HRESP),     32'h1);
        chk("se_err1_psel",      32'(bus.PSEL),      32'h0);
        chk("se_err1_penable",   32'(bus.PENABLE),   32'h0);
        step(); #1;
        chk("se_err2_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("se_err2_hresp",     32'(bus.HRESP),     32'h1);

        // ---- PREADY stuck low: timeout after 16 ACCESS cycles
        step(); ahb_addr(32'h0000, 1'b0, 2'd2); #1;
        step(); ahb_idle(); bus.PREADY = 1'b0; #1;
        chk("to_setup_psel", 32'(bus.PSEL), 32'h1);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            step(); #1;
            if (bus.PENABLE !== 1'b1) break;
            acc++;
        end
        chk("to_access_cycles", acc,                32'd16);
        chk("to_err1_hreadyout", 32'(bus.HREADYOUT), 32'h0);
        chk("to_err1_hresp",     32'(bus.HRESP),     32'h1);
        chk("to_err1_psel",      32'(bus.PSEL),      32'h0);
        step(); bus.PREADY = 1'b1; #1;
        chk("to_err2_hresp", 32'(bus.HRESP), 32'h1);

        // ---- reset during ACCESS, then a clean read
        step(); ahb_addr(32'h1000, 1'b0, 2'd2); #1;
        step(); ahb_idle(); bus.PREADY = 1'b0; #1;
        step(); HRESET = 1'b1; #1;
        chk("rs_in_access_penable", 32'(bus.PENABLE), 32'h1);
        step(); HRESET = 1'b0; bus.PREADY = 1'b1; #1;
        chk("rs_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rs_hresp",     32'(bus.HRESP),     32'h0);
        chk("rs_hrdata",    bus.HRDATA,         32'h0);
        chk("rs_psel",      32'(bus.PSEL),      32'h0);
        chk("rs_penable",   32'(bus.PENABLE),   32'h0);
        chk("rs_paddr",     bus.PADDR,          32'h0);
        chk("rs_pwrite",    32'(bus.PWRITE),    32'h0);
        chk("rs_pstrb",     32'(bus.PSTRB),     32'h0);
        step(); ahb_addr(32'h2010, 1'b0, 2'd2); bus.PRDATA = 32'hCAFEF00D; #1;
        step(); ahb_idle(); #1;
        chk("rs_rd_setup_psel", 32'(bus.PSEL), 32'h4);
        step(); #1;
        step(); #1;
        chk("rs_rd_done_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rs_rd_done_hresp",     32'(bus.HRESP),     32'h0);
        chk("rs_rd_done_hrdata",    bus.HRDATA,         32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
